fire5_expand1_bias_seq: RTL and testbench



---
 rtl/fire5_bias_seq_pkg.sv | 24 ++
 rtl/fire5_expand1_bias_seq_requant.sv | 38 +++
 rtl/fire5_expand1_bias_seq.sv | 141 ++++++++++++++
 tb/tb_fire5_expand1_bias_seq.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fire5_bias_seq_pkg.sv
// fire5 expand1 bias sequencer: shared sizes, FSM states and data types.
// Optional ReLU via FIRE5_EXPAND1_BIAS_SEQ_RELU_EN.
package fire5_bias_seq_pkg;

    localparam int NUM_CH  = 128;
    localparam int NUM_PIX = 729;
    localparam int ACC_W   = 32;
    localparam int OUT_W   = 16;
    localparam int SHIFT   = 8;
    localparam int CH_W    = $clog2(NUM_CH);
    localparam int PIX_W   = $clog2(NUM_PIX);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [ACC_W:0]   sum_t;
    typedef logic signed [OUT_W-1:0] act_t;

endpackage

// File: rtl/fire5_expand1_bias_seq_requant.sv
// bias_requant: arithmetic shift, signed saturation and optional ReLU.
// ReLU enabled by FIRE5_EXPAND1_BIAS_SEQ_RELU_EN; sat flags clipping only.
module bias_requant
    import fire5_bias_seq_pkg::*;
(
    input  logic [ACC_W:0]   sum,
    output logic [OUT_W-1:0] res,
    output logic             sat
);

    localparam logic [OUT_W-1:0] ACT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] ACT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    sum_t sh;
    logic hi;
    logic lo;

    // Value fits OUT_W bits only if all bits above the result sign agree.
    always_comb begin
        sh  = $signed(sum) >>> SHIFT;
        hi  = !sh[ACC_W] && (|sh[ACC_W-1:OUT_W-1]);
        lo  = sh[ACC_W] && !(&sh[ACC_W-1:OUT_W-1]);
        sat = hi || lo;
        if (hi) begin
            res = ACT_MAX;
        end else if (lo) begin
            res = ACT_MIN;
        end else begin
            res = sh[OUT_W-1:0];
        end
`ifdef FIRE5_EXPAND1_BIAS_SEQ_RELU_EN
        if (res[OUT_W-1]) begin
            res = '0;
        end
`endif
    end

endmodule

// File: rtl/fire5_expand1_bias_seq.sv
// fire5 expand1 bias sequencer: bias add, requant, 2-stage valid/ready pipe.
// Optional ReLU via FIRE5_EXPAND1_BIAS_SEQ_RELU_EN (inside bias_requant).
module fire5_expand1_bias_seq
    import fire5_bias_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic [ACC_W-1:0] bias_mem [NUM_CH],
    input  logic [ACC_W-1:0] acc_data,
    input  logic             acc_valid,
    output logic             acc_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH_W-1:0]  out_ch,
    output logic [15:0]      sat_count
);

    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIX - 1);

    state_t           state;
    logic [CH_W-1:0]  ch;
    logic [PIX_W-1:0] pix;

    logic             s1_v;
    sum_t             s1_sum;
    logic [CH_W-1:0]  s1_ch;

    logic             acc_hs;
    logic             s2_load;
    logic             last_beat;
    logic             start_acc;
    logic [OUT_W-1:0] rq_res;
    logic             rq_sat;

    assign acc_ready = (state == RUN) &&
                       (!s1_v || !out_valid || out_ready);
    assign acc_hs    = acc_valid && acc_ready;
    assign s2_load   = s1_v && (!out_valid || out_ready);
    assign last_beat = (ch == CH_LAST) && (pix == PIX_LAST);
    assign start_acc = (state == IDLE) && start;

    bias_requant u_requant (
        .sum (s1_sum),
        .res (rq_res),
        .sat (rq_sat)
    );

    // Frame control plus channel-fastest beat counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            ch    <= '0;
            pix   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        ch    <= '0;
                        pix   <= '0;
                    end
                end
                RUN: begin
                    if (acc_hs) begin
                        if (ch == CH_LAST) begin
                            ch  <= '0;
                            pix <= pix + 1'b1;
                        end else begin
                            ch <= ch + 1'b1;
                        end
                        if (last_beat) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready && !s1_v) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stage 1: widen accumulator and add this channel's bias.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v   <= 1'b0;
            s1_sum <= '0;
            s1_ch  <= '0;
        end else begin
            if (acc_hs) begin
                s1_v   <= 1'b1;
                s1_sum <= sum_t'($signed(acc_data)) +
                          sum_t'($signed(bias_mem[ch]));
                s1_ch  <= ch;
            end else if (s2_load) begin
                s1_v <= 1'b0;
            end
        end
    end

    // Stage 2: register requantised result; count clips once per beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            sat_count <= '0;
        end else begin
            if (start_acc) begin
                sat_count <= '0;
            end else if (s2_load && rq_sat &&
                         (sat_count != 16'hFFFF)) begin
                sat_count <= sat_count + 16'd1;
            end
            if (s2_load) begin
                out_valid <= 1'b1;
                out_data  <= rq_res;
                out_ch    <= s1_ch;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fire5_expand1_bias_seq.sv
// Bench for fire5_expand1_bias_seq: directed vectors plus a queue model.
// Expectations follow FIRE5_EXPAND1_BIAS_SEQ_RELU_EN when it is defined.
module tb_fire5_expand1_bias_seq;
    import fire5_bias_seq_pkg::*;

    localparam int TOTAL = NUM_CH * NUM_PIX;
`ifdef FIRE5_EXPAND1_BIAS_SEQ_RELU_EN
    localparam int EXP1    = 0;
    localparam int EXP_NEG = 0;
`else
    localparam int EXP1    = -1;
    localparam int EXP_NEG = -32768;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] bias_mem [NUM_CH];
    logic [ACC_W-1:0] acc_data = '0;
    logic             acc_valid = 1'b0;
    logic             acc_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [CH_W-1:0]  out_ch;
    logic [15:0]      sat_count;

    fire5_expand1_bias_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .bias_mem  (bias_mem),
        .acc_data  (acc_data),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_acc_ready"}, acc_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_ch"}, out_ch, 0);
        chk({tag, "_sat_count"}, sat_count, 0);
    endtask

    // Reference requantisation using plain integer arithmetic.
    function automatic void model_req(input logic [31:0] a,
                                      input logic [31:0] b,
                                      output int r, output bit s);
        longint sum;
        longint sh;
        sum = longint'($signed(a)) + longint'($signed(b));
        sh  = sum >>> SHIFT;
        s   = 1'b0;
        if (sh > 32767) begin
            r = 32767;
            s = 1'b1;
        end else if (sh < -32768) begin
            r = -32768;
            s = 1'b1;
        end else begin
            r = int'(sh);
        end
`ifdef FIRE5_EXPAND1_BIAS_SEQ_RELU_EN
        if (r < 0) r = 0;
`endif
    endfunction

    typedef struct {
        int data;
        int ch;
        int sat;
        int idx;
    } exp_t;

    exp_t q[$];
    int   m_idx = 0;
    int   m_sat = 0;
    bit   m_busy = 1'b0;
    bit   m_done = 1'b0;
    int   pops = 0;
    int   done_cnt = 0;

    // Model and compare, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        int   r;
        bit   s;
        bit   nxt_done;
        nxt_done = 1'b0;
        if (!rst_n) begin
            q.delete();
            m_idx  = 0;
            m_sat  = 0;
            m_busy = 1'b0;
            m_done = 1'b0;
        end else begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            if (!m_busy) chk("acc_ready_idle", acc_ready, 0);
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_extra actual=valid required=none");
                end else begin
                    chk("out_data", int'($signed(out_data)), q[0].data);
                    chk("out_ch", out_ch, q[0].ch);
                    chk("sat_count", sat_count, q[0].sat);
                    if (out_ready) begin
                        e = q.pop_front();
                        pops++;
                        if (e.idx == TOTAL - 1) nxt_done = 1'b1;
                    end
                end
            end
            if (acc_valid && acc_ready) begin
                model_req(acc_data, bias_mem[m_idx % NUM_CH], r, s);
                if (s && m_sat < 65535) m_sat++;
                q.push_back('{r, m_idx % NUM_CH, m_sat, m_idx});
                m_idx++;
            end
            if (done) done_cnt++;
            if (start && !m_busy && !m_done) begin
                m_busy = 1'b1;
                m_idx  = 0;
                m_sat  = 0;
            end
            if (nxt_done) m_busy = 1'b0;
            m_done = nxt_done;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        int sent;
        int c;
        int p0;
        int d0;
        int w;
        bit rnd;
        for (int i = 0; i < NUM_CH; i++) bias_mem[i] = 32'(i * 37 - 2000);
        bias_mem[0] = 32'd554;
        bias_mem[1] = 32'hFFFF_FFCE;

        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst0");
        rst_n = 1'b1;

        // Bias add and two-cycle latency.
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        acc_valid = 1'b1;
        acc_data = 32'd1000;
        @(negedge clk);
        chk("t1_ready", acc_ready, 1);
        chk("t1_ov0", out_valid, 0);
        cyc();
        acc_data = 32'd0;
        @(negedge clk);
        chk("t1_lat1", out_valid, 0);
        cyc();
        acc_valid = 1'b0;
        @(negedge clk);
        chk("t1_ov", out_valid, 1);
        chk("t1_d0", int'($signed(out_data)), 6);
        chk("t1_ch0", out_ch, 0);
        cyc();
        @(negedge clk);
        chk("t1_d1", int'($signed(out_data)), EXP1);
        chk("t1_ch1", out_ch, 1);
        cyc();
        @(negedge clk);
        chk("t1_ov_end", out_valid, 0);
        do_reset();

        // Positive and negative saturation on channel 0.
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k <= 130; k++) begin
            acc_valid = (k <= 128);
            acc_data = (k == 0) ? 32'h7FFF_FFFF :
                       (k == 128) ? 32'h8000_0000 : 32'd0;
            @(negedge clk);
            if (k == 2) begin
                chk("t2_pos", int'($signed(out_data)), 32767);
                chk("t2_sat1", sat_count, 1);
            end
            if (k == 130) begin
                chk("t2_neg", int'($signed(out_data)), EXP_NEG);
                chk("t2_negch", out_ch, 0);
                chk("t2_sat2", sat_count, 2);
            end
            cyc();
        end
        acc_valid = 1'b0;
        do_reset();

        // Backpressure: 10 beats, then out_ready low for 5 cycles.
        start = 1'b1;
        cyc();
        start = 1'b0;
        p0 = pops;
        sent = 0;
        c = 0;
        while (sent < 20 && c < 200) begin
            out_ready = !(c >= 10 && c < 15);
            acc_valid = 1'b1;
            acc_data = 32'(sent * 1000 - 7000);
            @(negedge clk);
            if (c == 9) chk("t3_ready_pre", acc_ready, 1);
            if (c == 10) chk("t3_ready_stall", acc_ready, 0);
            if (c == 14) begin
                chk("t3_hold_v", out_valid, 1);
                chk("t3_hold_ch", out_ch, 8);
            end
            if (acc_valid && acc_ready) sent++;
            cyc();
            c++;
        end
        acc_valid = 1'b0;
        out_ready = 1'b1;
        chk("t3_sent", sent, 20);
        repeat (5) cyc();
        chk("t3_pops", pops - p0, 20);
        do_reset();

        // Reset mid-frame at beat 500, then restart.
        start = 1'b1;
        cyc();
        start = 1'b0;
        sent = 0;
        c = 0;
        while (sent < 500 && c < 1000) begin
            acc_valid = 1'b1;
            acc_data = 32'(c * 13);
            @(negedge clk);
            if (acc_ready) sent++;
            cyc();
            c++;
        end
        chk("t4_sent", sent, 500);
        acc_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset("t4_rst");
        cyc();
        rst_n = 1'b1;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        acc_valid = 1'b1;
        acc_data = 32'd256;
        @(negedge clk);
        chk("t4_ready", acc_ready, 1);
        cyc();
        acc_valid = 1'b0;
        cyc();
        @(negedge clk);
        chk("t4_ov", out_valid, 1);
        chk("t4_ch", out_ch, 0);
        chk("t4_d", int'($signed(out_data)), 3);
        do_reset();

        // Full frame with random valid/ready at both ends.
        p0 = pops;
        d0 = done_cnt;
        start = 1'b1;
        cyc();
        start = 1'b0;
        sent = 0;
        c = 0;
        while (sent < TOTAL && c < TOTAL + 2000) begin
            rnd = (sent < 300) || (sent > TOTAL - 300);
            acc_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            start = (c == 50);
            acc_data = $urandom;
            @(negedge clk);
            if (acc_valid && acc_ready) sent++;
            cyc();
            c++;
        end
        start = 1'b0;
        acc_valid = 1'b0;
        chk("t5_sent", sent, TOTAL);
        w = 0;
        while (done_cnt == d0 && w < 500) begin
            out_ready = $urandom_range(0, 1);
            cyc();
            w++;
        end
        out_ready = 1'b1;
        chk("t5_done_seen", done_cnt - d0, 1);
        repeat (5) cyc();
        chk("t5_done_once", done_cnt - d0, 1);
        chk("t5_busy", busy, 0);
        chk("t5_pops", pops - p0, TOTAL);
        chk("t5_queue", q.size(), 0);
        chk("t5_sat_hold", sat_count, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
